// File: rtl/sequenciador_irrigacao.sv
// Actuator sequencer: turns irrigation requests into interlocked pump/valve drives
// with valve-first ordering, min/max run times, post-timeout rest and fault lockout.
module sequenciador_irrigacao #(
  parameter int W          = 16,
  parameter int T_ABRE     = 4,
  parameter int T_MIN      = 16,
  parameter int T_MAX      = 200,
  parameter int T_FECHA    = 4,
  parameter int T_DESCANSO = 32
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Aspersao,
  input  logic       Gotejamento,
  input  logic       Erro,
  input  logic       Alarme,
  output logic       Bomba,
  output logic       ValvAsp,
  output logic       ValvGot,
  output logic       Bloqueado,
  output logic [2:0] Estado,
  output logic [7:0] Ciclos
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ABRE     = 3'd1;
  localparam logic [2:0] S_RODA     = 3'd2;
  localparam logic [2:0] S_DRENA    = 3'd3;
  localparam logic [2:0] S_DESCANSO = 3'd4;
  localparam logic [2:0] S_BLOQ     = 3'd5;

  localparam logic [W-1:0] C_ABRE     = W'(T_ABRE - 1);
  localparam logic [W-1:0] C_MIN      = W'(T_MIN - 1);
  localparam logic [W-1:0] C_MAX      = W'(T_MAX - 1);
  localparam logic [W-1:0] C_FECHA    = W'(T_FECHA - 1);
  localparam logic [W-1:0] C_DESCANSO = W'(T_DESCANSO - 1);

  logic [2:0]   estado_q, estado_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         modo_q, modo_d;
  logic         flag_falha_q, flag_falha_d;
  logic         flag_tout_q, flag_tout_d;
  logic [7:0]   ciclos_q, ciclos_d;
  logic         bomba_q, va_q, vg_q, bloq_q;
  logic         falha_s;
  logic         pedido_s;
  logic         sai_roda_s;
  logic         em_ciclo_s;

  assign falha_s  = Erro | Alarme;
  // Only the request that started the run can end it; the other one is ignored.
  assign pedido_s = modo_q ? Gotejamento : Aspersao;

  // Next-state, counter, mode, flags and run counter.
  always_comb begin
    estado_d     = estado_q;
    modo_d       = modo_q;
    flag_falha_d = flag_falha_q;
    flag_tout_d  = flag_tout_q;
    sai_roda_s   = 1'b0;
    case (estado_q)
      S_IDLE: begin
        if (falha_s) begin
          estado_d = S_BLOQ;
        end else if (Aspersao) begin
          estado_d = S_ABRE;
          modo_d   = 1'b0;
        end else if (Gotejamento) begin
          estado_d = S_ABRE;
          modo_d   = 1'b1;
        end else begin
          estado_d = S_IDLE;
        end
      end
      S_ABRE: begin
        if (falha_s) begin
          estado_d = S_BLOQ;
        end else if (cnt_q == C_ABRE) begin
          estado_d = S_RODA;
        end else begin
          estado_d = S_ABRE;
        end
      end
      S_RODA: begin
        if (falha_s) begin
          estado_d     = S_DRENA;
          flag_falha_d = 1'b1;
          sai_roda_s   = 1'b1;
        end else if (cnt_q == C_MAX) begin
          estado_d    = S_DRENA;
          flag_tout_d = 1'b1;
          sai_roda_s  = 1'b1;
        end else if (!pedido_s && (cnt_q >= C_MIN)) begin
          estado_d   = S_DRENA;
          sai_roda_s = 1'b1;
        end else begin
          estado_d = S_RODA;
        end
      end
      S_DRENA: begin
        if (cnt_q == C_FECHA) begin
          flag_falha_d = 1'b0;
          flag_tout_d  = 1'b0;
          if (flag_falha_q || falha_s) begin
            estado_d = S_BLOQ;
          end else if (flag_tout_q) begin
            estado_d = S_DESCANSO;
          end else begin
            estado_d = S_IDLE;
          end
        end else begin
          estado_d = S_DRENA;
        end
      end
      S_DESCANSO: begin
        if (falha_s) begin
          estado_d = S_BLOQ;
        end else if (cnt_q == C_DESCANSO) begin
          estado_d = S_IDLE;
        end else begin
          estado_d = S_DESCANSO;
        end
      end
      S_BLOQ: begin
        if (falha_s) begin
          estado_d = S_BLOQ;
        end else begin
          estado_d = S_IDLE;
        end
      end
      default: begin
        estado_d     = S_IDLE;
        flag_falha_d = 1'b0;
        flag_tout_d  = 1'b0;
      end
    endcase

    if (estado_d != estado_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end

    if (sai_roda_s && (ciclos_q != 8'd255)) begin
      ciclos_d = ciclos_q + 8'd1;
    end else begin
      ciclos_d = ciclos_q;
    end
  end

  assign em_ciclo_s = (estado_d == S_ABRE) || (estado_d == S_RODA) || (estado_d == S_DRENA);

  // State registers; drives are registered from the next state so they track Estado exactly.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q     <= S_IDLE;
      cnt_q        <= '0;
      modo_q       <= 1'b0;
      flag_falha_q <= 1'b0;
      flag_tout_q  <= 1'b0;
      ciclos_q     <= 8'd0;
      bomba_q      <= 1'b0;
      va_q         <= 1'b0;
      vg_q         <= 1'b0;
      bloq_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      modo_q       <= modo_d;
      flag_falha_q <= flag_falha_d;
      flag_tout_q  <= flag_tout_d;
      ciclos_q     <= ciclos_d;
      bomba_q      <= (estado_d == S_RODA);
      va_q         <= em_ciclo_s & ~modo_d;
      vg_q         <= em_ciclo_s & modo_d;
      bloq_q       <= (estado_d == S_BLOQ);
    end
  end

  assign Bomba     = bomba_q;
  assign ValvAsp   = va_q;
  assign ValvGot   = vg_q;
  assign Bloqueado = bloq_q;
  assign Estado    = estado_q;
  assign Ciclos    = ciclos_q;

endmodule

// File: tb/tb_sequenciador_irrigacao.sv
// Directed bench for sequenciador_irrigacao: stepwise vector table plus
// measured multi-cycle sequences (T_MIN run, timeout/rest, saturation).
module tb_sequenciador_irrigacao;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Aspersao = 1'b0;
  logic       Gotejamento = 1'b0;
  logic       Erro = 1'b0;
  logic       Alarme = 1'b0;
  logic       Bomba, ValvAsp, ValvGot, Bloqueado;
  logic [2:0] Estado;
  logic [7:0] Ciclos;

  int total = 0;
  int bad = 0;

  always #5 Clock = ~Clock;

  sequenciador_irrigacao dut (
    .Clock(Clock), .Reset(Reset), .Aspersao(Aspersao), .Gotejamento(Gotejamento),
    .Erro(Erro), .Alarme(Alarme), .Bomba(Bomba), .ValvAsp(ValvAsp), .ValvGot(ValvGot),
    .Bloqueado(Bloqueado), .Estado(Estado), .Ciclos(Ciclos)
  );

  typedef struct {
    logic       rst, asp, got, erro, alm;
    int         n;
    logic [2:0] est;
    logic       bomba, va, vg, bloq;
    logic [7:0] cic;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic r, input logic a, input logic g, input logic e,
                             input logic al, input int n, input logic [2:0] es,
                             input logic b, input logic xa, input logic xg,
                             input logic bl, input logic [7:0] c);
    vec_t t;
    t.rst = r; t.asp = a; t.got = g; t.erro = e; t.alm = al; t.n = n;
    t.est = es; t.bomba = b; t.va = xa; t.vg = xg; t.bloq = bl; t.cic = c;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    int c_bomba, c_va, c_vg, c_drena, c_desc;
    bit done, seen_desc;

    // rst asp got erro alm  n   est b va vg bl cic
    vt.push_back(v(1,0,0,0,0, 2, 3'd0,0,0,0,0,8'd0));
    // sprinkler run, request dropped well after T_MIN
    vt.push_back(v(0,1,0,0,0, 1, 3'd1,0,1,0,0,8'd0));
    vt.push_back(v(0,1,0,0,0, 3, 3'd1,0,1,0,0,8'd0));
    vt.push_back(v(0,1,0,0,0, 1, 3'd2,1,1,0,0,8'd0));
    vt.push_back(v(0,1,0,0,0,30, 3'd2,1,1,0,0,8'd0));
    vt.push_back(v(0,0,0,0,0, 1, 3'd3,0,1,0,0,8'd1));
    vt.push_back(v(0,0,0,0,0, 3, 3'd3,0,1,0,0,8'd1));
    vt.push_back(v(0,0,0,0,0, 1, 3'd0,0,0,0,0,8'd1));
    // short drip pulse: runs exactly T_MIN
    vt.push_back(v(0,0,1,0,0, 3, 3'd1,0,0,1,0,8'd1));
    vt.push_back(v(0,0,0,0,0, 1, 3'd1,0,0,1,0,8'd1));
    vt.push_back(v(0,0,0,0,0, 1, 3'd2,1,0,1,0,8'd1));
    vt.push_back(v(0,0,0,0,0,15, 3'd2,1,0,1,0,8'd1));
    vt.push_back(v(0,0,0,0,0, 1, 3'd3,0,0,1,0,8'd2));
    vt.push_back(v(0,0,0,0,0, 3, 3'd3,0,0,1,0,8'd2));
    vt.push_back(v(0,0,0,0,0, 1, 3'd0,0,0,0,0,8'd2));
    // one-cycle alarm at pump cycle 5
    vt.push_back(v(0,1,0,0,0, 5, 3'd2,1,1,0,0,8'd2));
    vt.push_back(v(0,1,0,0,0, 4, 3'd2,1,1,0,0,8'd2));
    vt.push_back(v(0,0,0,0,1, 1, 3'd3,0,1,0,0,8'd3));
    vt.push_back(v(0,0,0,0,0, 3, 3'd3,0,1,0,0,8'd3));
    vt.push_back(v(0,0,0,0,0, 1, 3'd5,0,0,0,1,8'd3));
    vt.push_back(v(0,0,0,0,0, 1, 3'd0,0,0,0,0,8'd3));
    // sensor error during valve opening
    vt.push_back(v(0,1,0,0,0, 2, 3'd1,0,1,0,0,8'd3));
    vt.push_back(v(0,1,0,1,0, 1, 3'd5,0,0,0,1,8'd3));
    vt.push_back(v(0,1,0,1,0, 2, 3'd5,0,0,0,1,8'd3));
    vt.push_back(v(0,0,0,0,0, 1, 3'd0,0,0,0,0,8'd3));
    // fault while idle
    vt.push_back(v(0,0,0,0,1, 1, 3'd5,0,0,0,1,8'd3));
    vt.push_back(v(0,0,0,0,0, 1, 3'd0,0,0,0,0,8'd3));
    // both requests: sprinkler wins; then reset mid-run
    vt.push_back(v(0,1,1,0,0, 1, 3'd1,0,1,0,0,8'd3));
    vt.push_back(v(0,1,1,0,0, 4, 3'd2,1,1,0,0,8'd3));
    vt.push_back(v(1,1,1,0,0, 1, 3'd0,0,0,0,0,8'd0));
    vt.push_back(v(0,0,0,0,0, 1, 3'd0,0,0,0,0,8'd0));

    for (int i = 0; i < vt.size(); i++) begin
      Reset = vt[i].rst; Aspersao = vt[i].asp; Gotejamento = vt[i].got;
      Erro = vt[i].erro; Alarme = vt[i].alm;
      tick(vt[i].n);
      chk($sformatf("vec%0d{est,b,va,vg,bl,cic}", i),
          int'({Estado, Bomba, ValvAsp, ValvGot, Bloqueado, Ciclos}),
          int'({vt[i].est, vt[i].bomba, vt[i].va, vt[i].vg, vt[i].bloq, vt[i].cic}));
    end

    // drip pulse of 3 cycles: measure drive durations
    c_bomba = 0; c_va = 0; c_vg = 0; done = 1'b0;
    Gotejamento = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      tick(1);
      if (i == 2) Gotejamento = 1'b0;
      if (Estado == 3'd0) begin
        done = 1'b1;
      end else begin
        c_bomba += int'(Bomba); c_va += int'(ValvAsp); c_vg += int'(ValvGot);
      end
    end
    chk("got_run_done", int'(done), 1);
    chk("got_bomba_cycles", c_bomba, 16);
    chk("got_valvgot_cycles", c_vg, 24);
    chk("got_valvasp_cycles", c_va, 0);
    chk("got_ciclos", int'(Ciclos), 1);

    // held request: timeout at T_MAX, drain, rest, then a new opening
    c_bomba = 0; c_drena = 0; c_desc = 0; done = 1'b0; seen_desc = 1'b0;
    Aspersao = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      tick(1);
      if (Estado == 3'd1 && seen_desc) begin
        done = 1'b1;
      end else begin
        c_bomba += int'(Bomba);
        if (Estado == 3'd3) c_drena++;
        if (Estado == 3'd4) begin
          seen_desc = 1'b1;
          if (!Bomba && !ValvAsp && !ValvGot) c_desc++;
        end
      end
    end
    chk("tout_reabre", int'(done), 1);
    chk("tout_bomba_cycles", c_bomba, 200);
    chk("tout_drena_cycles", c_drena, 4);
    chk("tout_descanso_cycles", c_desc, 32);
    chk("tout_ciclos", int'(Ciclos), 2);
    Aspersao = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick(1);
      if (Estado == 3'd0) done = 1'b1;
    end
    chk("tout_next_run_done", int'(done), 1);
    chk("tout_next_ciclos", int'(Ciclos), 3);

    // 256 short runs: counter saturates at 255
    for (int r = 0; r < 256; r++) begin
      Gotejamento = 1'b1;
      tick(1);
      Gotejamento = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
        tick(1);
        if (Estado == 3'd0) done = 1'b1;
      end
      chk($sformatf("sat_run%0d_done", r), int'(done), 1);
      if (r == 251) chk("sat_reach_255", int'(Ciclos), 255);
    end
    chk("sat_hold_255", int'(Ciclos), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
